// File: rtl/adder_bist_ctrl.sv
// Built-in self-test controller for combinational adders: sweeps every {A,B,Cin}
// vector, waits SETTLE cycles, samples the adder and tallies mismatches.
module adder_bist_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 cin_o,
    input  logic [WIDTH-1:0]     s_i,
    input  logic                 cout_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH:0]     first_fail_vec
);

    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [VW-1:0] r_v, w_v_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_pass, w_pass_nxt;
    logic [15:0]   r_err, w_err_nxt;
    logic [VW-1:0] r_ff, w_ff_nxt;

    logic [SW-1:0] w_expected;
    logic [SW-1:0] w_actual;
    logic          w_mismatch;
    logic [15:0]   w_err_inc;
    logic [15:0]   w_err_after;
    logic          w_last;

    // The vector counter itself drives the adder operands.
    assign a_o            = r_v[VW-1:WIDTH+1];
    assign b_o            = r_v[WIDTH:1];
    assign cin_o          = r_v[0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ff;

    assign w_expected  = {1'b0, a_o} + {1'b0, b_o} + SW'(cin_o);
    assign w_actual    = {cout_i, s_i};
    assign w_mismatch  = (w_expected != w_actual);
    assign w_err_inc   = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
    assign w_err_after = w_mismatch ? w_err_inc : r_err;
    assign w_last      = (r_v == {VW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_v     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ff    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_ff    <= w_ff_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_ff_nxt    = r_ff;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_v_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = '0;
                    w_ff_nxt    = '0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CW'(SETTLE - 1)) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt = w_err_inc;
                    if (r_err == 16'd0) begin
                        w_ff_nxt = r_v;
                    end
                end
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_after == 16'd0);
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_v_nxt     = r_v + VW'(1);
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Self-checking bench for adder_bist_ctrl: a 4-bit instance against a delayed,
// fault-injectable adder model, plus a 1-bit full-adder instance.
module tb_adder_bist_ctrl;

    typedef struct {
        int          mode;
        logic [15:0] err;
        logic [8:0]  ff;
        logic        pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  a4, b4, s4;
    logic        cin4, cout4, busy4, done4, pass4;
    logic [15:0] err4;
    logic [8:0]  ff4;

    logic        start1 = 1'b0;
    logic [0:0]  a1, b1, s1;
    logic        cin1, cout1, busy1, done1, pass1;
    logic [15:0] err1;
    logic [2:0]  ff1;

    int          fault = 0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        sb_q[$];

    logic [8:0]  p1 = '0, p2 = '0;
    logic [4:0]  sum4;
    logic [2:0]  q1 = '0;
    logic [1:0]  sum1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder model with two cycles of latency: only correct if sampled SETTLE+1 cycles after drive.
    always @(posedge clk) begin
        p1 <= {a4, b4, cin4};
        p2 <= p1;
        q1 <= {a1, b1, cin1};
    end
    assign sum4  = {1'b0, p2[8:5]} + {1'b0, p2[4:1]} + {4'd0, p2[0]};
    assign s4    = (fault == 1) ? {sum4[3:1], 1'b0} : sum4[3:0];
    assign cout4 = (fault == 2) ? 1'b1 : sum4[4];
    assign sum1  = {1'b0, q1[2]} + {1'b0, q1[1]} + {1'b0, q1[0]};
    assign s1    = sum1[0:0];
    assign cout1 = sum1[1];

    adder_bist_ctrl #(.WIDTH(4), .SETTLE(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a4), .b_o(b4), .cin_o(cin4), .s_i(s4), .cout_i(cout4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail_vec(ff4)
    );

    adder_bist_ctrl #(.WIDTH(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1), .cin_o(cin1), .s_i(s1), .cout_i(cout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ff1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One full 4-bit run; expected result is queued at start and popped when done rises.
    task automatic run4(input vec_t e, input bit hold);
        int   k;
        int   bad;
        bit   got;
        vec_t x;
        fault = e.mode;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        k = cyc;
        chk("k_busy", 32'(busy4), 32'd1);
        chk("k_vec", 32'({a4, b4, cin4}), 32'd0);
        chk("k_done", 32'({done4, pass4}), 32'd0);
        chk("k_err", 32'({err4, ff4}), 32'd0);
        bad = 0;
        got = 1'b0;
        for (int m = 1; m <= 2000 && !got; m++) begin
            @(negedge clk);
            if (done4) got = 1'b1;
            else if ({a4, b4, cin4} != 9'(m / 3) || !busy4 || pass4) bad++;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_cycle", 32'(cyc - k), 32'd1536);
        chk("vec_seq", 32'(bad), 32'd0);
        chk("done_busy", 32'(busy4), 32'd0);
        chk("last_vec", 32'({a4, b4, cin4}), 32'h1FF);
        x = sb_q.pop_front();
        chk("err_count", 32'(err4), 32'(x.err));
        chk("first_fail", 32'(ff4), 32'(x.ff));
        chk("pass", 32'(pass4), 32'(x.pass));
    endtask

    initial begin
        vec_t tbl[3];
        vec_t ideal;
        int   k;
        int   bad;
        bit   got;

        tbl[0] = '{mode: 0, err: 16'd0,   ff: 9'h000, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 16'd256, ff: 9'h001, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 16'd256, ff: 9'h000, pass: 1'b0};
        ideal  = tbl[0];

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({a4, b4, cin4, busy4, done4, pass4}), 32'd0);
        chk("rst_err", 32'({err4, ff4}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'({busy4, done4}), 32'd0);

        for (int i = 0; i < 3; i++) run4(tbl[i], 1'b0);

        // Restart from DONE after a failing run, holding start high throughout.
        run4(ideal, 1'b1);
        repeat (3) @(negedge clk);
        chk("done_stays", 32'({done4, busy4, pass4}), 32'b101);

        // Reset mid-run abandons a failing run completely.
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        chk("mid_err_nonzero", 32'(err4 != 16'd0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_outs", 32'({a4, b4, cin4, busy4, done4, pass4}), 32'd0);
        chk("mid_rst_err", 32'({err4, ff4}), 32'd0);
        run4(ideal, 1'b0);

        // 1-bit full adder, SETTLE=1: 8 vectors, 2 cycles each.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = cyc;
        chk("fa_k", 32'({busy1, a1, b1, cin1}), 32'b1000);
        bad = 0;
        got = 1'b0;
        for (int m = 1; m <= 100 && !got; m++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
            else if ({a1, b1, cin1} != 3'(m / 2)) bad++;
        end
        chk("fa_done_seen", 32'(got), 32'd1);
        chk("fa_done_cycle", 32'(cyc - k), 32'd16);
        chk("fa_vec_seq", 32'(bad), 32'd0);
        chk("fa_result", 32'({pass1, busy1, err1, ff1}), 32'({1'b1, 1'b0, 16'd0, 3'd0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
